// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES key-schedule engine.
package aes_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] round_key_t;

    typedef enum logic {
        IDLE,
        EXPAND
    } state_t;

    localparam logic [7:0] RCON_INIT = 8'h01;

    function automatic int key_nk(input int key_length);
        return key_length / 32;
    endfunction

    function automatic int key_nr(input int key_length);
        return key_length / 32 + 6;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) begin
                acc = acc ^ x;
            end
            x = xtime(x);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_key_word_step.sv
// Combinational key-expansion step: produces w[i] from w[i-NK], w[i-1], i mod NK and rcon.
module aes_key_word_step
    import aes_pkg::*;
#(
    parameter int NK = 8
) (
    input  word_t      prev_nk_i,
    input  word_t      prev_word_i,
    input  logic [2:0] idx_mod_i,
    input  logic [7:0] rcon_i,
    output word_t      next_word_o
);

    word_t sub_in;
    word_t sub_out;
    word_t f_word;

    // RotWord only applies on the NK boundary; the NK==8 mid-point uses a plain SubWord.
    assign sub_in = (idx_mod_i == 3'd0) ? {prev_word_i[23:0], prev_word_i[31:24]} : prev_word_i;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .in_i  (sub_in[8*b +: 8]),
            .out_o (sub_out[8*b +: 8])
        );
    end

    always_comb begin
        f_word = prev_word_i;
        if (idx_mod_i == 3'd0) begin
            f_word = sub_out ^ {rcon_i, 24'h000000};
        end else if ((NK == 8) && (idx_mod_i == 3'd4)) begin
            f_word = sub_out;
        end
    end

    assign next_word_o = prev_nk_i ^ f_word;

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box computed algebraically: inverse in GF(2^8) as x^254, then the affine map.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

    // Addition chain 2,3,6,12,15,30,60,120,240,252,254; zero maps to zero naturally.
    assign x2   = gf_mul(in_i, in_i);
    assign x3   = gf_mul(x2, in_i);
    assign x6   = gf_mul(x3, x3);
    assign x12  = gf_mul(x6, x6);
    assign x15  = gf_mul(x12, x3);
    assign x30  = gf_mul(x15, x15);
    assign x60  = gf_mul(x30, x30);
    assign x120 = gf_mul(x60, x60);
    assign x240 = gf_mul(x120, x120);
    assign x252 = gf_mul(x240, x12);
    assign inv  = gf_mul(x252, x2);

    assign out_o = inv
                 ^ {inv[6:0], inv[7]}
                 ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]}
                 ^ 8'h63;

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES-128/192/256 key schedule: one word per clock into a buffer,
// with a registered round-key read port.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter  int KEY_LENGTH = 256,
    localparam int NK         = key_nk(KEY_LENGTH),
    localparam int NR         = key_nr(KEY_LENGTH),
    localparam int NUM_WORDS  = 4 * (NR + 1),
    localparam int RW         = $clog2(NR + 1)
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Key_valid,
    output logic                  Key_ready,
    input  logic [KEY_LENGTH-1:0] Input_key,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Keys_valid,
    input  logic [RW-1:0]         Round_number,
    output round_key_t            Round_key
);

    localparam int IW = $clog2(NUM_WORDS + 1);

    if ((KEY_LENGTH != 128) && (KEY_LENGTH != 192) && (KEY_LENGTH != 256)) begin : g_bad_key_length
        $error("aes_key_schedule: KEY_LENGTH must be 128, 192 or 256");
    end

    state_t     state_q, state_d;
    word_t      words_q [NUM_WORDS];
    word_t      win_q   [NK];
    logic [IW-1:0] idx_q;
    logic [2:0] mod_q;
    logic [7:0] rcon_q;
    logic       done_q;
    logic       keys_valid_q;
    round_key_t round_key_q;
    round_key_t rd_data;
    word_t      next_word;
    logic       accept;
    logic       last_word;

    assign accept    = Key_valid && (state_q == IDLE);
    assign last_word = (state_q == EXPAND) && (idx_q == IW'(NUM_WORDS - 1));

    aes_key_word_step #(
        .NK (NK)
    ) u_step (
        .prev_nk_i   (win_q[0]),
        .prev_word_i (win_q[NK-1]),
        .idx_mod_i   (mod_q),
        .rcon_i      (rcon_q),
        .next_word_o (next_word)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = EXPAND;
            EXPAND:  if (last_word) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Key_ready = 1'b0;
        Busy      = 1'b0;
        case (state_q)
            IDLE:    Key_ready = 1'b1;
            EXPAND:  Busy      = 1'b1;
            default: Key_ready = 1'b0;
        endcase
    end

    // Word counter, i mod NK tracker and rcon advance together; rcon steps only on the NK boundary.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            idx_q        <= '0;
            mod_q        <= 3'd0;
            rcon_q       <= RCON_INIT;
            done_q       <= 1'b0;
            keys_valid_q <= 1'b0;
            round_key_q  <= '0;
        end else begin
            done_q      <= last_word;
            round_key_q <= rd_data;
            if (accept) begin
                idx_q        <= IW'(NK);
                mod_q        <= 3'd0;
                rcon_q       <= RCON_INIT;
                keys_valid_q <= 1'b0;
            end else if (state_q == EXPAND) begin
                idx_q <= idx_q + IW'(1);
                mod_q <= (mod_q == 3'(NK - 1)) ? 3'd0 : mod_q + 3'd1;
                if (mod_q == 3'd0) begin
                    rcon_q <= xtime(rcon_q);
                end
                if (last_word) begin
                    keys_valid_q <= 1'b1;
                end
            end
        end
    end

    // Schedule storage is deliberately left unreset; Keys_valid qualifies its contents.
    always_ff @(posedge Clk) begin
        if (accept) begin
            for (int k = 0; k < NK; k++) begin
                words_q[k] <= Input_key[KEY_LENGTH-1-32*k -: 32];
                win_q[k]   <= Input_key[KEY_LENGTH-1-32*k -: 32];
            end
        end else if (state_q == EXPAND) begin
            words_q[idx_q] <= next_word;
            for (int k = 0; k < NK - 1; k++) begin
                win_q[k] <= win_q[k+1];
            end
            win_q[NK-1] <= next_word;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int r = 0; r <= NR; r++) begin
            if (Round_number == RW'(r)) begin
                rd_data = {words_q[4*r], words_q[4*r+1], words_q[4*r+2], words_q[4*r+3]};
            end
        end
    end

    assign Done       = done_q;
    assign Keys_valid = keys_valid_q;
    assign Round_key  = round_key_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboard bench driving AES-128/192/256 instances from one shared key bus
// (smaller sizes take the leading words) against a textbook expansion model.
module tb_aes_key_schedule;

    typedef struct {
        int           due;
        int           kind;
        logic [127:0] exp;
        string        name;
    } chk_t;

    localparam logic [3:0] ST_RESET  = 4'b1000;
    localparam logic [3:0] ST_BUSY   = 4'b0100;
    localparam logic [3:0] ST_DONE   = 4'b1011;
    localparam logic [3:0] ST_LOADED = 4'b1001;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         Key_valid;
    logic [255:0] keyIn;
    logic [3:0]   roundNum;
    logic [2:0]   readyV, busyV, doneV, kvV;
    logic [127:0] rk0, rk1, rk2;

    int   cyc = 0;
    int   passCount = 0;
    int   checkCount = 0;
    chk_t sbq[$];

    logic [7:0] sbox [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };
    logic [7:0]  rconTab [10] = '{8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36};
    logic [31:0] sched [3][60];

    aes_key_schedule #(.KEY_LENGTH(128)) dut128 (
        .Clk(Clk), .Rst(Rst), .Key_valid(Key_valid), .Key_ready(readyV[0]),
        .Input_key(keyIn[255:128]), .Busy(busyV[0]), .Done(doneV[0]), .Keys_valid(kvV[0]),
        .Round_number(roundNum), .Round_key(rk0)
    );

    aes_key_schedule #(.KEY_LENGTH(192)) dut192 (
        .Clk(Clk), .Rst(Rst), .Key_valid(Key_valid), .Key_ready(readyV[1]),
        .Input_key(keyIn[255:64]), .Busy(busyV[1]), .Done(doneV[1]), .Keys_valid(kvV[1]),
        .Round_number(roundNum), .Round_key(rk1)
    );

    aes_key_schedule #(.KEY_LENGTH(256)) dut256 (
        .Clk(Clk), .Rst(Rst), .Key_valid(Key_valid), .Key_ready(readyV[2]),
        .Input_key(keyIn), .Busy(busyV[2]), .Done(doneV[2]), .Keys_valid(kvV[2]),
        .Round_number(roundNum), .Round_key(rk2)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [31:0] subWord(input logic [31:0] x);
        return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
    endfunction

    // Textbook FIPS-197 expansion for all three key sizes from the same leading key words.
    task automatic buildModel(input logic [255:0] key);
        for (int s = 0; s < 3; s++) begin
            int nk;
            int nw;
            logic [31:0] t;
            nk = 4 + 2 * s;
            nw = 4 * (nk + 7);
            for (int i = 0; i < nw; i++) begin
                if (i < nk) begin
                    sched[s][i] = key[255-32*i -: 32];
                end else begin
                    t = sched[s][i-1];
                    if (i % nk == 0) begin
                        t = subWord({t[23:0], t[31:24]}) ^ {rconTab[i/nk-1], 24'h000000};
                    end else if (nk == 8 && i % 8 == 4) begin
                        t = subWord(t);
                    end
                    sched[s][i] = sched[s][i-nk] ^ t;
                end
            end
        end
    endtask

    function automatic logic [127:0] expRound(input int s, input int r);
        if (r > 10 + 2 * s) return '0;
        return {sched[s][4*r], sched[s][4*r+1], sched[s][4*r+2], sched[s][4*r+3]};
    endfunction

    function automatic logic [127:0] observe(input int kind);
        case (kind)
            0:       return rk0;
            1:       return rk1;
            2:       return rk2;
            3:       return {124'b0, readyV[0], busyV[0], doneV[0], kvV[0]};
            4:       return {124'b0, readyV[1], busyV[1], doneV[1], kvV[1]};
            5:       return {124'b0, readyV[2], busyV[2], doneV[2], kvV[2]};
            default: return 'x;
        endcase
    endfunction

    function automatic logic [255:0] randKey();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic pushChk(input int due, input int kind, input logic [127:0] exp, input string name);
        chk_t c;
        c.due  = due;
        c.kind = kind;
        c.exp  = exp;
        c.name = name;
        sbq.push_back(c);
    endtask

    task automatic checkOutput(input chk_t c);
        logic [127:0] act;
        act = observe(c.kind);
        checkCount++;
        if (c.due < cyc) begin
            $display("[TB] FAIL %s (kind %0d): expected at cycle %0d, not checked until %0d",
                     c.name, c.kind, c.due, cyc);
        end else if (act !== c.exp) begin
            $display("[TB] FAIL %s (kind %0d) cycle %0d: got %h, expected %h",
                     c.name, c.kind, cyc, act, c.exp);
        end else begin
            passCount++;
        end
    endtask

    // Monitor: every scoreboard entry whose cycle has come is compared against the DUT.
    always @(negedge Clk) begin
        for (int k = sbq.size() - 1; k >= 0; k--) begin
            if (sbq[k].due <= cyc) begin
                checkOutput(sbq[k]);
                sbq.delete(k);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [255:0] key, input bit expectDone,
                                 input int holdCycles, input logic [255:0] holdKey);
        int c;
        int nk;
        int lat;
        c         = cyc;
        keyIn     = key;
        Key_valid = 1'b1;
        buildModel(key);
        tick();
        for (int s = 0; s < 3; s++) begin
            pushChk(c + 1, 3 + s, 128'(ST_BUSY), "status after accept");
            if (expectDone) begin
                nk  = 4 + 2 * s;
                lat = 4 * (nk + 7) - nk;
                pushChk(c + lat,     3 + s, 128'(ST_BUSY),   "status before done");
                pushChk(c + 1 + lat, 3 + s, 128'(ST_DONE),   "done pulse");
                pushChk(c + 2 + lat, 3 + s, 128'(ST_LOADED), "status after done");
            end
        end
        if (holdCycles > 0) begin
            keyIn = holdKey;
            repeat (holdCycles) tick();
        end
        Key_valid = 1'b0;
    endtask

    task automatic readSweep();
        for (int r = 0; r < 16; r++) begin
            roundNum = 4'(r);
            for (int s = 0; s < 3; s++) begin
                pushChk(cyc + 1, s, expRound(s, r), "round key sweep");
            end
            tick();
        end
        roundNum = '0;
    endtask

    task automatic readKat(input int s, input int r, input logic [127:0] v);
        roundNum = 4'(r);
        pushChk(cyc + 1, s, v, "known-answer round key");
        tick();
        roundNum = '0;
    endtask

    task automatic resetMidExpansion(input logic [255:0] key);
        applyStimulus(key, 1'b0, 0, '0);
        repeat (19) tick();
        Rst = 1'b1;
        tick();
        for (int s = 0; s < 3; s++) begin
            pushChk(cyc, 3 + s, 128'(ST_RESET), "status after mid reset");
            pushChk(cyc, s, '0, "round key after mid reset");
        end
        Rst = 1'b0;
        repeat (20) tick();
        for (int s = 0; s < 3; s++) begin
            pushChk(cyc, 3 + s, 128'(ST_RESET), "no done after mid reset");
        end
        tick();
    endtask

    initial begin
        Rst       = 1'b1;
        Key_valid = 1'b0;
        keyIn     = '0;
        roundNum  = '0;
        tick();
        tick();
        for (int s = 0; s < 3; s++) begin
            pushChk(cyc, 3 + s, 128'(ST_RESET), "reset status");
            pushChk(cyc, s, '0, "reset round key");
        end
        Rst = 1'b0;
        tick();

        applyStimulus(256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4,
                      1'b1, 0, '0);
        repeat (60) tick();
        readSweep();
        readKat(2, 14, 128'hfe4890d1_e6188d0b_046df344_706c631e);
        readKat(2, 15, 128'h0);

        applyStimulus({192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b, $urandom(), $urandom()},
                      1'b1, 37, randKey());
        repeat (60) tick();
        readSweep();
        readKat(1, 12, 128'he98ba06f_448c773c_8ecc7204_01002202);
        readKat(1, 0,  128'h8e73b0f7_da0e6452_c810f32b_809079e5);

        applyStimulus({128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, $urandom(), $urandom(), $urandom(), $urandom()},
                      1'b1, 0, '0);
        repeat (60) tick();
        readSweep();
        readKat(0, 1,  128'ha0fafe17_88542cb1_23a33939_2a6c7605);
        readKat(0, 10, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);

        resetMidExpansion(randKey());

        repeat (2) begin
            applyStimulus(randKey(), 1'b1, 0, '0);
            repeat (60) tick();
            readSweep();
        end

        repeat (3) tick();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not reach its summary in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
